// File: rtl/fifo_sync_pkg.sv
// rtl/fifo_sync_pkg.sv - shared widths and read-mode encoding for fifo_sync_param
package fifo_sync_pkg;

    localparam int DEFAULT_DEPTH = 32;
    localparam int PTR_W         = $clog2(DEFAULT_DEPTH);
    localparam int CNT_W         = PTR_W + 1;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// rtl/fifo_sync_ram.sv - simple dual-port RAM, one write port, registered read port with enable
module fifo_sync_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; only the read register clears so dout starts at zero.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: a read of the address being written returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised sync FIFO with FWFT mode; FIFO_SYNC_PARAM_ERR_EN adds sticky overflow/underflow
module fifo_sync_param
    import fifo_sync_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     almost_empty,
`ifdef FIFO_SYNC_PARAM_ERR_EN
    output logic                     overflow,
    output logic                     underflow,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam bit IS_FWFT = (FWFT == MODE_FWFT);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_TH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt_next, ram_words;
    logic          rd_acc, wr_acc, prefetch, ram_re;
    logic          out_valid, valid_next, empty_next;

    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    // In FWFT mode count includes the head register, so the RAM holds count minus that word.
    assign ram_words  = count - CW'(out_valid);
    assign prefetch   = (ram_words != '0) & (~out_valid | rd_acc);
    assign ram_re     = IS_FWFT ? prefetch : rd_acc;
    assign valid_next = IS_FWFT ? (prefetch | (out_valid & ~rd_acc)) : 1'b0;
    assign empty_next = IS_FWFT ? ~valid_next : (cnt_next == '0);

    always_comb begin
        cnt_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_next = count + 1'b1;
            2'b01:   cnt_next = count - 1'b1;
            default: cnt_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            out_valid    <= 1'b0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= cnt_next;
            out_valid    <= valid_next;
            empty        <= empty_next;
            full         <= (cnt_next == DEPTH_C);
            almost_empty <= (cnt_next <= AE_C);
            almost_full  <= (cnt_next >= AF_C);
        end
    end

`ifdef FIFO_SYNC_PARAM_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full & ~rd_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en & empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    fifo_sync_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed self-checking bench for standard and FWFT fifo_sync_param
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       s_rst = 1'b1, s_wr = 1'b0, s_rd = 1'b0;
    logic [7:0] s_din = '0, s_dout;
    logic       s_full, s_af, s_empty, s_ae;
    logic [5:0] s_cnt;
    logic       f_rst = 1'b1, f_wr = 1'b0, f_rd = 1'b0;
    logic [7:0] f_din = '0, f_dout;
    logic       f_full, f_af, f_empty, f_ae;
    logic [5:0] f_cnt;
`ifdef FIFO_SYNC_PARAM_ERR_EN
    logic       s_ovf, s_unf, f_ovf, f_unf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(.WIDTH(8), .DEPTH(32), .FWFT(0)) u_std (
        .clk(clk), .rst(s_rst), .wr_en(s_wr), .din(s_din), .full(s_full),
        .almost_full(s_af), .rd_en(s_rd), .dout(s_dout), .empty(s_empty),
        .almost_empty(s_ae),
`ifdef FIFO_SYNC_PARAM_ERR_EN
        .overflow(s_ovf), .underflow(s_unf),
`endif
        .count(s_cnt)
    );

    fifo_sync_param #(.WIDTH(8), .DEPTH(32), .FWFT(1)) u_fwft (
        .clk(clk), .rst(f_rst), .wr_en(f_wr), .din(f_din), .full(f_full),
        .almost_full(f_af), .rd_en(f_rd), .dout(f_dout), .empty(f_empty),
        .almost_empty(f_ae),
`ifdef FIFO_SYNC_PARAM_ERR_EN
        .overflow(f_ovf), .underflow(f_unf),
`endif
        .count(f_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset and idle state, standard mode
        tick(); tick();
        s_rst = 1'b0; f_rst = 1'b0;
        tick();
        chk("rst_count", 32'(s_cnt), 0);
        chk("rst_empty", 32'(s_empty), 1);
        chk("rst_aempty", 32'(s_ae), 1);
        chk("rst_full", 32'(s_full), 0);
        chk("rst_afull", 32'(s_af), 0);
        chk("rst_dout", 32'(s_dout), 0);

        s_rd = 1'b1;
        tick(); tick(); tick();
        s_rd = 1'b0;
        chk("underrun_count", 32'(s_cnt), 0);
        chk("underrun_empty", 32'(s_empty), 1);
        chk("underrun_dout", 32'(s_dout), 0);
`ifdef FIFO_SYNC_PARAM_ERR_EN
        chk("underflow_set", 32'(s_unf), 1);
        chk("overflow_clr", 32'(s_ovf), 0);
`endif

        // Fill with 0x01..0x20
        for (int i = 1; i <= 32; i++) begin
            s_wr = 1'b1; s_din = 8'(i);
            tick();
            chk("fill_count", 32'(s_cnt), i);
            if (i == 1)  chk("fill_empty1", 32'(s_empty), 0);
            if (i == 2)  chk("fill_aempty2", 32'(s_ae), 1);
            if (i == 3)  chk("fill_aempty3", 32'(s_ae), 0);
            if (i == 29) chk("fill_afull29", 32'(s_af), 0);
            if (i == 30) chk("fill_afull30", 32'(s_af), 1);
            if (i == 31) chk("fill_full31", 32'(s_full), 0);
            if (i == 32) chk("fill_full32", 32'(s_full), 1);
        end
        s_din = 8'h99;
        tick();
        chk("drop_count", 32'(s_cnt), 32);
        chk("drop_full", 32'(s_full), 1);
`ifdef FIFO_SYNC_PARAM_ERR_EN
        chk("overflow_set", 32'(s_ovf), 1);
`endif

        // Simultaneous write+read while full
        s_din = 8'hAA; s_rd = 1'b1;
        tick();
        s_wr = 1'b0;
        chk("full_rw_dout", 32'(s_dout), 32'h01);
        chk("full_rw_count", 32'(s_cnt), 32);
        chk("full_rw_full", 32'(s_full), 1);

        for (int i = 2; i <= 32; i++) begin
            tick();
            chk("drain_dout", 32'(s_dout), i);
        end
        chk("drain_count1", 32'(s_cnt), 1);
        tick();
        s_rd = 1'b0;
        chk("drain_last", 32'(s_dout), 32'hAA);
        chk("drain_count0", 32'(s_cnt), 0);
        chk("drain_empty", 32'(s_empty), 1);

        // Pointer wrap with steady occupancy of 5
        s_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_din = 8'(8'h40 + i);
            tick();
        end
        s_rd = 1'b1;
        for (int k = 0; k < 40; k++) begin
            s_din = 8'(8'h45 + k);
            tick();
            chk("wrap_dout", 32'(s_dout), 32'h40 + k);
            chk("wrap_count", 32'(s_cnt), 5);
        end
        s_rd = 1'b0;

        // Mid-stream reset at count 17
        for (int i = 0; i < 12; i++) begin
            s_din = 8'(8'h70 + i);
            tick();
        end
        chk("pre_rst_count", 32'(s_cnt), 17);
        s_rst = 1'b1; s_rd = 1'b1;
        tick();
        s_rst = 1'b0; s_wr = 1'b0; s_rd = 1'b0;
        chk("mid_rst_count", 32'(s_cnt), 0);
        chk("mid_rst_empty", 32'(s_empty), 1);
        chk("mid_rst_full", 32'(s_full), 0);
        chk("mid_rst_dout", 32'(s_dout), 0);
`ifdef FIFO_SYNC_PARAM_ERR_EN
        chk("mid_rst_ovf", 32'(s_ovf), 0);
`endif
        s_wr = 1'b1; s_din = 8'h3C;
        tick();
        s_wr = 1'b0;
        chk("post_rst_wr_empty", 32'(s_empty), 0);
        s_rd = 1'b1;
        tick();
        s_rd = 1'b0;
        chk("post_rst_dout", 32'(s_dout), 32'h3C);
        chk("post_rst_empty", 32'(s_empty), 1);

        // FWFT: single word latency and pop
        chk("fw_rst_empty", 32'(f_empty), 1);
        chk("fw_rst_dout", 32'(f_dout), 0);
        f_wr = 1'b1; f_din = 8'h5C;
        tick();
        f_wr = 1'b0;
        chk("fw_lat1_empty", 32'(f_empty), 1);
        chk("fw_lat1_count", 32'(f_cnt), 1);
        tick();
        chk("fw_lat2_empty", 32'(f_empty), 0);
        chk("fw_lat2_dout", 32'(f_dout), 32'h5C);
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        chk("fw_pop_empty", 32'(f_empty), 1);
        chk("fw_pop_count", 32'(f_cnt), 0);

        // FWFT: full capacity and ordered drain
        f_wr = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            f_din = 8'(8'h80 + i);
            tick();
        end
        f_wr = 1'b0;
        chk("fw_full", 32'(f_full), 1);
        chk("fw_full_count", 32'(f_cnt), 32);
        for (int i = 1; i <= 32; i++) begin
            chk("fw_drain_dout", 32'(f_dout), 32'h80 + i);
            f_rd = 1'b1;
            tick();
        end
        f_rd = 1'b0;
        chk("fw_drain_empty", 32'(f_empty), 1);
        chk("fw_drain_count", 32'(f_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock synchronous FIFO. Successor to the team's basic FIFO.
- Adds a selectable first-word-fall-through (FWFT) read mode.
- Adds programmable almost-full/almost-empty thresholds and an occupancy count.
- Defines accept rules for every full/empty boundary case.
- Sits between streaming producers/consumers (e.g. tap/data buffering in the FIR datapath).

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 32: storage words; power of two, >= 4.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AFULL_TH, DEPTH-2: almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- full  out  1  no free entry.
- almost_full  out  1  count >= AFULL_TH.
- rd_en  in  1  read/pop request.
- dout  out  WIDTH  read data.
- empty  out  1  no readable word.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  $clog2(DEPTH)+1  words currently held.

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0, dout=0, pointers=0. Reset wins over any simultaneous wr_en/rd_en; mid-operation reset discards contents in one cycle.
- All flags are registered and derived from the next-state count, so they are consistent with count in the same cycle.
- Accept rules:
  - rd_acc = rd_en & ~empty.
  - wr_acc = wr_en & (~full | rd_acc). When full, a simultaneous read and write are both accepted and count is unchanged.
  - Read or write while empty (no simultaneous write): request ignored, no state change.
  - Write while full without a read: dropped, din not stored.
- Count update: count_next = count + wr_acc - rd_acc. Width is $clog2(DEPTH)+1; never exceeds DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0. No pointer rewrite on full.
- Standard mode (FWFT=0):
  - dout loads mem[rd_ptr] on the edge where rd_acc=1, so data is valid the cycle after rd_en. dout holds otherwise.
  - Write to an empty FIFO: empty deasserts the next cycle.
  - Write and read in the same cycle while empty: only the write is accepted.
- FWFT mode (FWFT=1):
  - An internal output register holds the head word; dout is valid whenever empty=0. rd_en is an acknowledge.
  - Write into an empty FIFO: empty deasserts 2 cycles later (RAM write, then prefetch).
  - After a pop, the next word is visible the following cycle if one is stored; otherwise empty asserts.
  - count includes the prefetched word, so capacity stays DEPTH.
- Storage: synchronous-write, synchronous-read RAM. No reset of RAM contents; dout must never expose unwritten entries.

Optional Feature:
- Macro: FIFO_SYNC_PARAM_ERR_EN.
- When defined: adds outputs overflow and underflow (1 bit each), sticky, cleared only by rst.
  - overflow sets on wr_en & full & ~rd_acc.
  - underflow sets on rd_en & empty.
- When undefined: ports absent, dropped requests are silent, no extra flops.

Decomposition:
- Package fifo_sync_pkg holds:
  - clog2-based width helper constants (PTR_W, CNT_W).
  - the FWFT mode encoding constants (MODE_STD=0, MODE_FWFT=1).
- Sub-module fifo_sync_ram: simple dual-port RAM, WIDTH x DEPTH, one write port, one registered read port with read enable.
- Top holds pointers, count, flags and the FWFT prefetch control.

Test Plan:
- Reset then idle: count=0, empty=1, almost_empty=1, full=0, dout=0. rd_en=1 for 3 cycles -> no change (underflow=1 if ERR_EN).
- FWFT=0: write 0x01..0x20 (32 words) -> full=1 one cycle after the 32nd write; almost_full=1 at count 30. A 33rd write is dropped. Reads return 0x01..0x20 in order, each one cycle after rd_en.
- Full with simultaneous wr_en=1 (din=0xAA) and rd_en=1 -> count stays 32, full stays 1. 0xAA is read last, after 31 further pops.
- Wrap: 40 continuous write+read pairs at count=5 -> data order preserved across the pointer wrap; count stays 5.
- FWFT=1: single write of 0x5C into an empty FIFO -> empty=0 and dout=0x5C 2 cycles later. rd_en=1 -> empty=1 the next cycle, count=0.
- Reset asserted at count=17 mid-stream -> next cycle count=0, empty=1, full=0. The first post-reset write/read round-trips correctly.
